// File: rtl/and_gate_top_pkg.sv
// Shared types and constants for the and_gate_top cell: input-combination
// encoding, counter defaults and the combination decoder.
package and_gate_top_pkg;

    typedef enum logic [1:0] {
        COMBO_00 = 2'b00,
        COMBO_01 = 2'b01,
        COMBO_10 = 2'b10,
        COMBO_11 = 2'b11
    } combo_e;

    localparam int DEFAULT_CNT_W = 8;
    localparam int NUM_COMBOS    = 4;

    // One-hot strobe for the combination applied this cycle
    function automatic logic [NUM_COMBOS-1:0] combo_onehot(input combo_e combo);
        logic [NUM_COMBOS-1:0] v;
        case (combo)
            COMBO_00: v = 4'b0001;
            COMBO_01: v = 4'b0010;
            COMBO_10: v = 4'b0100;
            COMBO_11: v = 4'b1000;
            default:  v = 4'b0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/and_gate_top_sat_cnt.sv
// Saturating up-counter: counts inc strobes, holds at all-ones, never wraps.
module and_gate_top_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] MAX_VAL = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_q;

    // Count register with async clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= {CNT_W{1'b0}};
        end else if (inc && (r_q != MAX_VAL)) begin
            r_q <= r_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_q <= r_q;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/and_gate_top.sv
// Two-input AND cell with registered copy and optional input-combination
// coverage (sticky flags + saturating hit counters) under AND_GATE_TOP_COVER_EN.
module and_gate_top
    import and_gate_top_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      a,
    input  logic                      b,
    output logic                      c,
    output logic                      c_q,
    output logic [NUM_COMBOS-1:0]     cov_seen,
    output logic                      cov_all,
    output logic [NUM_COMBOS*CNT_W-1:0] hit_cnt
);

    logic r_c_q;

    assign c = a & b;

    // Registered copy of the AND result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c_q <= 1'b0;
        end else begin
            r_c_q <= a & b;
        end
    end

    assign c_q = r_c_q;

`ifdef AND_GATE_TOP_COVER_EN
    logic                  w_valid;
    logic [NUM_COMBOS-1:0] w_hit;
    logic [NUM_COMBOS-1:0] r_cov_seen;

    // Unknown inputs must not be attributed to any combination
    assign w_valid = !$isunknown({a, b});

    // Decode the applied combination into a one-hot strobe
    always_comb begin
        w_hit = 4'b0000;
        if (w_valid) begin
            w_hit = combo_onehot(combo_e'({a, b}));
        end else begin
            w_hit = 4'b0000;
        end
    end

    // Sticky per-combination seen flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cov_seen <= 4'b0000;
        end else begin
            r_cov_seen <= r_cov_seen | w_hit;
        end
    end

    for (genvar k = 0; k < NUM_COMBOS; k++) begin : g_cnt
        and_gate_top_sat_cnt #(
            .CNT_W (CNT_W)
        ) u_sat_cnt (
            .clk (clk),
            .rst (rst),
            .inc (w_hit[k]),
            .q   (hit_cnt[k*CNT_W +: CNT_W])
        );
    end

    assign cov_seen = r_cov_seen;
    assign cov_all  = &r_cov_seen;
`else
    assign cov_seen = {NUM_COMBOS{1'b0}};
    assign cov_all  = 1'b0;
    assign hit_cnt  = {(NUM_COMBOS*CNT_W){1'b0}};
`endif

endmodule

// File: tb/tb_and_gate_top.sv
// Directed bench for and_gate_top (CNT_W=2); coverage expectations follow
// whether AND_GATE_TOP_COVER_EN is defined for the build.
module tb_and_gate_top;

    localparam int CW = 2;
`ifdef AND_GATE_TOP_COVER_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic          clk;
    logic          clk_en;
    logic          rst;
    logic          a;
    logic          b;
    logic          c;
    logic          c_q;
    logic [3:0]    cov_seen;
    logic          cov_all;
    logic [4*CW-1:0] hit_cnt;

    int total;
    int bad;

    and_gate_top #(.CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .c        (c),
        .c_q      (c_q),
        .cov_seen (cov_seen),
        .cov_all  (cov_all),
        .hit_cnt  (hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = clk_en ? ~clk : 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #3;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #10;
        total++; if (c_q !== 1'b0) begin bad++; $display("FAIL reset_c_q got=%b want=0", c_q); end
        total++; if (cov_seen !== 4'b0000) begin bad++; $display("FAIL reset_cov_seen got=%b want=0000", cov_seen); end
        total++; if (cov_all !== 1'b0) begin bad++; $display("FAIL reset_cov_all got=%b want=0", cov_all); end
        total++; if (hit_cnt !== 8'h00) begin bad++; $display("FAIL reset_hit_cnt got=%h want=00", hit_cnt); end
    endtask

    task automatic test_truth_table();
        logic [1:0] vec [4];
        logic       exp [4];
        vec = '{2'b00, 2'b01, 2'b10, 2'b11};
        exp = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            {a, b} = vec[i];
            #10;
            total++;
            if (c !== exp[i]) begin
                bad++; $display("FAIL truth_%b got=%b want=%b", vec[i], c, exp[i]);
            end
        end
    endtask

    task automatic test_registered();
        do_reset();
        a = 1'b1; b = 1'b1;
        #1;
        total++; if (c_q !== 1'b0) begin bad++; $display("FAIL reg_before got=%b want=0", c_q); end
        tick();
        total++; if (c_q !== 1'b1) begin bad++; $display("FAIL reg_after got=%b want=1", c_q); end
    endtask

    task automatic test_coverage();
        logic [1:0] vec [4];
        vec = '{2'b00, 2'b01, 2'b10, 2'b11};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            {a, b} = vec[i];
            tick();
        end
        total++; if (cov_seen !== (EN ? 4'b1111 : 4'b0000)) begin bad++; $display("FAIL cov_seen got=%b want=%b", cov_seen, EN ? 4'b1111 : 4'b0000); end
        total++; if (cov_all !== EN) begin bad++; $display("FAIL cov_all got=%b want=%b", cov_all, EN); end
        total++; if (hit_cnt !== (EN ? 8'b01010101 : 8'h00)) begin bad++; $display("FAIL cov_hit_cnt got=%b want=%b", hit_cnt, EN ? 8'b01010101 : 8'h00); end
        total++; if (c_q !== 1'b1) begin bad++; $display("FAIL cov_c_q got=%b want=1", c_q); end
        total++; if (c !== 1'b1) begin bad++; $display("FAIL cov_c got=%b want=1", c); end
    endtask

    task automatic test_async_reset();
        #3;
        rst = 1'b1;
        #1;
        total++; if (c_q !== 1'b0) begin bad++; $display("FAIL arst_c_q got=%b want=0", c_q); end
        total++; if (cov_seen !== 4'b0000) begin bad++; $display("FAIL arst_cov_seen got=%b want=0000", cov_seen); end
        total++; if (cov_all !== 1'b0) begin bad++; $display("FAIL arst_cov_all got=%b want=0", cov_all); end
        total++; if (hit_cnt !== 8'h00) begin bad++; $display("FAIL arst_hit_cnt got=%h want=00", hit_cnt); end
        total++; if (c !== 1'b1) begin bad++; $display("FAIL arst_c got=%b want=1", c); end
        #1;
        rst = 1'b0;
        a = 1'b1; b = 1'b1;
        tick();
        total++; if (c_q !== 1'b1) begin bad++; $display("FAIL arst_first_c_q got=%b want=1", c_q); end
        total++; if (cov_seen !== (EN ? 4'b1000 : 4'b0000)) begin bad++; $display("FAIL arst_first_cov got=%b want=%b", cov_seen, EN ? 4'b1000 : 4'b0000); end
        total++; if (hit_cnt !== (EN ? 8'b01000000 : 8'h00)) begin bad++; $display("FAIL arst_first_hit got=%b want=%b", hit_cnt, EN ? 8'b01000000 : 8'h00); end
    endtask

    task automatic test_saturation();
        do_reset();
        a = 1'b1; b = 1'b0;
        tick();
        tick();
        total++; if (hit_cnt !== (EN ? 8'b00100000 : 8'h00)) begin bad++; $display("FAIL sat_two got=%b want=%b", hit_cnt, EN ? 8'b00100000 : 8'h00); end
        tick();
        tick();
        tick();
        total++; if (hit_cnt !== (EN ? 8'b00110000 : 8'h00)) begin bad++; $display("FAIL sat_five got=%b want=%b", hit_cnt, EN ? 8'b00110000 : 8'h00); end
        total++; if (cov_seen !== (EN ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL sat_cov got=%b want=%b", cov_seen, EN ? 4'b0100 : 4'b0000); end
        total++; if (cov_all !== 1'b0) begin bad++; $display("FAIL sat_cov_all got=%b want=0", cov_all); end
        total++; if (c_q !== 1'b0) begin bad++; $display("FAIL sat_c_q got=%b want=0", c_q); end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        clk_en = 1'b0;
        rst    = 1'b1;
        a      = 1'b0;
        b      = 1'b0;
        test_reset();
        test_truth_table();
        rst    = 1'b0;
        clk_en = 1'b1;
        #1;
        test_registered();
        test_coverage();
        test_async_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
